// File: rtl/stream_mux_pkg.sv
// Shared encodings and default sizing for the N-channel stream multiplexer.
package stream_mux_pkg;

  localparam int N_CH_DEF = 4;
  localparam int W_DEF    = 32;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

endpackage

// File: rtl/stream_mux_n_if.sv
// Handshake bundle between N input streams, the mux, and one output stream.
interface stream_mux_n_if
  import stream_mux_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
  parameter int W    = W_DEF
) ();
  localparam int SEL_W = $clog2(N_CH);

  logic              mode;
  logic [SEL_W-1:0]  sel;
  logic [N_CH-1:0]   in_valid;
  logic [N_CH*W-1:0] in_data;
  logic [N_CH-1:0]   in_ready;
  logic              out_valid;
  logic [W-1:0]      out_data;
  logic [SEL_W-1:0]  out_ch;
  logic              out_ready;

  modport master (
    output mode, sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  mode, sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/stream_mux_n_rr_arbiter.sv
// Combinational round-robin picker: first requester strictly after ptr, wrapping.
module rr_arbiter #(
  parameter int N_CH  = 4,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic             grant_valid_o,
  output logic [SEL_W-1:0] grant_idx_o
);

  always_comb begin
    int unsigned cand;
    logic        found;
    found         = 1'b0;
    cand          = 0;
    grant_valid_o = 1'b0;
    grant_idx_o   = '0;
    for (int k = 1; k <= N_CH; k++) begin
      // ptr is always < N_CH, so one subtraction is enough to wrap.
      cand = 32'(ptr_i) + 32'(k);
      if (cand >= 32'(N_CH)) cand = cand - 32'(N_CH);
      if (!found && req_i[SEL_W'(cand)]) begin
        found       = 1'b1;
        grant_idx_o = SEL_W'(cand);
      end
    end
    grant_valid_o = found;
  end

endmodule

// File: rtl/stream_mux_n.sv
// N-to-1 stream multiplexer with fixed-select or round-robin arbitration and a registered output.
module stream_mux_n
  import stream_mux_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
  parameter int W    = W_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  stream_mux_n_if.slave mux_if
);
  localparam int SEL_W = $clog2(N_CH);

  logic             load;
  logic             xfer;
  logic             fixed_valid;
  logic             rr_valid;
  logic             grant_valid;
  logic [SEL_W-1:0] rr_idx;
  logic [SEL_W-1:0] grant_idx;
  logic [31:0]      sel_ext;
  logic [N_CH-1:0]  ready;
  logic             rr_mode;

  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_ch_q,    out_ch_d;
  logic [SEL_W-1:0] ptr_q,       ptr_d;

  assign rr_mode = (mux_if.mode == MODE_RR);
  assign load    = !out_valid_q || mux_if.out_ready;

  // An out-of-range sel must yield no grant rather than an X from the select.
  assign sel_ext     = 32'(mux_if.sel);
  assign fixed_valid = (sel_ext < 32'(N_CH)) ? mux_if.in_valid[mux_if.sel] : 1'b0;

  rr_arbiter #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_rr_arbiter (
    .req_i         (mux_if.in_valid),
    .ptr_i         (ptr_q),
    .grant_valid_o (rr_valid),
    .grant_idx_o   (rr_idx)
  );

  assign grant_valid = rr_mode ? rr_valid : fixed_valid;
  assign grant_idx   = rr_mode ? rr_idx   : mux_if.sel;

  // Ready is held low while reset is asserted even though load is 1 then.
  assign xfer = rst_n && load && grant_valid;

  always_comb begin
    ready = '0;
    if (xfer) ready[grant_idx] = 1'b1;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (load) out_valid_d = xfer;
    if (xfer) begin
      out_data_d = mux_if.in_data[int'(grant_idx)*W +: W];
      out_ch_d   = grant_idx;
      if (rr_mode) ptr_d = grant_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= SEL_W'(N_CH - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign mux_if.in_ready  = ready;
  assign mux_if.out_valid = out_valid_q;
  assign mux_if.out_data  = out_data_q;
  assign mux_if.out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_n.sv
// Directed bench for stream_mux_n: 4x32 main instance, 2x8 and 16x64 sweeps, 5x8 for out-of-range sel.
module tb_stream_mux_n;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  stream_mux_n_if #(.N_CH(4),  .W(32)) if4  ();
  stream_mux_n_if #(.N_CH(2),  .W(8))  if2  ();
  stream_mux_n_if #(.N_CH(16), .W(64)) if16 ();
  stream_mux_n_if #(.N_CH(5),  .W(8))  if5  ();

  stream_mux_n #(.N_CH(4),  .W(32)) dut4  (.clk(clk), .rst_n(rst_n), .mux_if(if4.slave));
  stream_mux_n #(.N_CH(2),  .W(8))  dut2  (.clk(clk), .rst_n(rst_n), .mux_if(if2.slave));
  stream_mux_n #(.N_CH(16), .W(64)) dut16 (.clk(clk), .rst_n(rst_n), .mux_if(if16.slave));
  stream_mux_n #(.N_CH(5),  .W(8))  dut5  (.clk(clk), .rst_n(rst_n), .mux_if(if5.slave));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    if4.mode = 1'b0; if4.sel = 2'd2; if4.in_valid = 4'hF; if4.out_ready = 1'b1;
    if4.in_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    if2.mode = 1'b0; if2.sel = '0; if2.in_valid = '0; if2.in_data = '0; if2.out_ready = 1'b1;
    if16.mode = 1'b0; if16.sel = '0; if16.in_valid = '0; if16.in_data = '0; if16.out_ready = 1'b1;
    if5.mode = 1'b0; if5.sel = '0; if5.in_valid = '0; if5.in_data = '0; if5.out_ready = 1'b1;

    // Reset state, with requests already pending.
    #1 rst_n = 1'b0;
    #2;
    chk("rst_valid", 64'(if4.out_valid), 64'd0);
    chk("rst_data",  64'(if4.out_data),  64'd0);
    chk("rst_ch",    64'(if4.out_ch),    64'd0);
    chk("rst_ready", 64'(if4.in_ready),  64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("s1_ready0", 64'(if4.in_ready), 64'h4);

    // Fixed select of channel 2.
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("s1_valid%0d", k), 64'(if4.out_valid), 64'd1);
      chk($sformatf("s1_data%0d", k),  64'(if4.out_data),  64'hA2);
      chk($sformatf("s1_ch%0d", k),    64'(if4.out_ch),    64'd2);
      chk($sformatf("s1_ready%0d", k), 64'(if4.in_ready),  64'h4);
    end

    // Round-robin, all requesting; pointer still at its reset value.
    if4.mode = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("s2_ready%0d", k), 64'(if4.in_ready), 64'(1 << (k % 4)));
      tick();
      chk($sformatf("s2_ch%0d", k),   64'(if4.out_ch),   64'(k % 4));
      chk($sformatf("s2_data%0d", k), 64'(if4.out_data), 64'(32'hA0 + (k % 4)));
    end

    // Sparse requests on channels 1 and 3.
    if4.in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("s3_ready%0d", k), 64'(if4.in_ready), ((k % 2) == 1) ? 64'h8 : 64'h2);
      tick();
      chk($sformatf("s3_ch%0d", k), 64'(if4.out_ch), ((k % 2) == 1) ? 64'd3 : 64'd1);
    end

    // Backpressure after a channel-1 transfer; mode switch while the word is held.
    if4.in_valid = 4'b0010;
    tick();
    chk("s4_load_ch", 64'(if4.out_ch), 64'd1);
    if4.out_ready = 1'b0;
    if4.in_valid  = 4'hF;
    #1;
    chk("s4_ready_hold", 64'(if4.in_ready), 64'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("s4_valid%0d", k), 64'(if4.out_valid), 64'd1);
      chk($sformatf("s4_data%0d", k),  64'(if4.out_data),  64'hA1);
      chk($sformatf("s4_ch%0d", k),    64'(if4.out_ch),    64'd1);
      chk($sformatf("s4_ready%0d", k), 64'(if4.in_ready),  64'd0);
      if (k == 3) begin
        if4.mode = 1'b0;
        if4.sel  = 2'd0;
      end
    end
    if4.out_ready = 1'b1;
    #1;
    chk("s4_release_ready", 64'(if4.in_ready), 64'h1);
    tick();
    chk("s4_nobubble_valid", 64'(if4.out_valid), 64'd1);
    chk("s4_nobubble_ch",    64'(if4.out_ch),    64'd0);
    chk("s4_nobubble_data",  64'(if4.out_data),  64'hA0);
    // Pointer untouched by the fixed-mode transfer: still 1, so channel 2 is next.
    if4.mode = 1'b1;
    #1;
    chk("s4_rr_ready", 64'(if4.in_ready), 64'h4);
    tick();
    chk("s4_rr_ch", 64'(if4.out_ch), 64'd2);

    // Idle cycle: output drains, data and channel hold.
    if4.in_valid = 4'h0;
    #1;
    chk("idle_ready", 64'(if4.in_ready), 64'd0);
    tick();
    chk("idle_valid", 64'(if4.out_valid), 64'd0);
    chk("idle_data",  64'(if4.out_data),  64'hA2);
    chk("idle_ch",    64'(if4.out_ch),    64'd2);

    // Reset pulse while a word is held.
    if4.in_valid = 4'hF;
    tick();
    chk("s5_pre_ch", 64'(if4.out_ch), 64'd3);
    if4.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("s5_rst_valid", 64'(if4.out_valid), 64'd0);
    chk("s5_rst_data",  64'(if4.out_data),  64'd0);
    chk("s5_rst_ch",    64'(if4.out_ch),    64'd0);
    chk("s5_rst_ready", 64'(if4.in_ready),  64'd0);
    tick();
    chk("s5_rst_hold_valid", 64'(if4.out_valid), 64'd0);
    rst_n = 1'b1;
    if4.out_ready = 1'b1;
    #1;
    chk("s5_post_ready", 64'(if4.in_ready), 64'h1);
    tick();
    chk("s5_post_valid", 64'(if4.out_valid), 64'd1);
    chk("s5_post_ch",    64'(if4.out_ch),    64'd0);
    chk("s5_post_data",  64'(if4.out_data),  64'hA0);
    if4.in_valid = 4'h0;

    // Out-of-range sel needs a non-power-of-two channel count to be encodable.
    if5.in_data  = {8'hB4, 8'hB3, 8'hB2, 8'hB1, 8'hB0};
    if5.in_valid = 5'h1F;
    if5.sel      = 3'd4;
    #1;
    chk("sel4_ready", 64'(if5.in_ready), 64'h10);
    tick();
    chk("sel4_valid", 64'(if5.out_valid), 64'd1);
    chk("sel4_data",  64'(if5.out_data),  64'hB4);
    chk("sel4_ch",    64'(if5.out_ch),    64'd4);
    if5.sel = 3'd5;
    #1;
    chk("sel5_ready", 64'(if5.in_ready), 64'd0);
    tick();
    chk("sel5_valid", 64'(if5.out_valid), 64'd0);
    chk("sel5_data",  64'(if5.out_data),  64'hB4);
    if5.sel = 3'd7;
    #1;
    chk("sel7_ready", 64'(if5.in_ready), 64'd0);
    tick();
    chk("sel7_valid", 64'(if5.out_valid), 64'd0);
    if5.in_valid = '0;

    // Two channels, 8 bits, one-hot data.
    if2.in_data  = {8'h02, 8'h01};
    if2.in_valid = 2'b11;
    if2.sel      = 1'b1;
    #1;
    chk("n2_fixed_ready", 64'(if2.in_ready), 64'h2);
    tick();
    chk("n2_fixed_data", 64'(if2.out_data), 64'h02);
    chk("n2_fixed_ch",   64'(if2.out_ch),   64'd1);
    if2.mode = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("n2_rr_ch%0d", k),   64'(if2.out_ch),   64'(k % 2));
      chk($sformatf("n2_rr_data%0d", k), 64'(if2.out_data), 64'(1 << (k % 2)));
    end
    if2.in_valid = '0;

    // Sixteen channels, 64 bits, one-hot data.
    for (int k = 0; k < 16; k++) if16.in_data[k*64 +: 64] = 64'd1 << k;
    if16.in_valid = 16'hFFFF;
    if16.sel      = 4'd9;
    #1;
    chk("n16_fixed_ready", 64'(if16.in_ready), 64'h200);
    tick();
    chk("n16_fixed_data", if16.out_data,        64'h200);
    chk("n16_fixed_ch",   64'(if16.out_ch),     64'd9);
    if16.mode = 1'b1;
    for (int k = 0; k < 18; k++) begin
      #1;
      chk($sformatf("n16_rr_ready%0d", k), 64'(if16.in_ready), 64'd1 << (k % 16));
      tick();
      chk($sformatf("n16_rr_ch%0d", k),   64'(if16.out_ch), 64'(k % 16));
      chk($sformatf("n16_rr_data%0d", k), if16.out_data,    64'd1 << (k % 16));
    end
    if16.in_valid = '0;

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
